// File: rtl/axi_burst_sequencer_if.sv
// Address-request, per-beat and error-response signals between the AXI slave
// front end and the beat engine, grouped for the burst sequencer.
interface axi_burst_sequencer_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_BYTES = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [3:0]            req_id;
  logic [ADDR_W-1:0]     req_addr;
  logic [7:0]            req_len;
  logic [2:0]            req_size;
  logic [1:0]            req_burst;

  logic                  beat_valid;
  logic                  beat_ready;
  logic [3:0]            beat_id;
  logic [ADDR_W-1:0]     beat_addr;
  logic [DATA_BYTES-1:0] beat_strb;
  logic [7:0]            beat_idx;
  logic                  beat_last;

  logic                  err_valid;
  logic [3:0]            err_id;
  logic [1:0]            err_resp;

  // Sequencer side: consumes requests, produces beats and error pulses.
  modport slave (
    input  req_valid, req_id, req_addr, req_len, req_size, req_burst, beat_ready,
    output req_ready, beat_valid, beat_id, beat_addr, beat_strb, beat_idx, beat_last,
           err_valid, err_id, err_resp
  );

  // Surrounding side: issues requests, consumes beats and error pulses.
  modport master (
    output req_valid, req_id, req_addr, req_len, req_size, req_burst, beat_ready,
    input  req_ready, beat_valid, beat_id, beat_addr, beat_strb, beat_idx, beat_last,
           err_valid, err_id, err_resp
  );
endinterface

// File: rtl/axi_burst_sequencer.sv
// Expands one AXI AR/AW request into per-beat address/strobe transactions
// (FIXED/INCR/WRAP); illegal requests get a single SLVERR pulse and no beats.
module axi_burst_sequencer #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_BYTES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_burst_sequencer_if.slave bus
);

  localparam int unsigned AW1     = ADDR_W + 1;
  localparam int unsigned LOG2_DB = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 0;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RESV  = 2'd3;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_ERR} state_e;

  state_e                state_q;
  logic                  req_ready_q;
  logic                  beat_valid_q;
  logic [3:0]            beat_id_q;
  logic [ADDR_W-1:0]     beat_addr_q;
  logic [DATA_BYTES-1:0] beat_strb_q;
  logic [7:0]            beat_idx_q;
  logic                  beat_last_q;
  logic                  err_valid_q;
  logic [3:0]            err_id_q;
  logic [1:0]            err_resp_q;

  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [ADDR_W-1:0]     wrap_lo_q;
  logic [ADDR_W-1:0]     wrap_hi_q;

  // Active lanes for a beat: from the beat's own byte offset up to the end of its size-aligned slot.
  function automatic logic [DATA_BYTES-1:0] strb_f(input logic [ADDR_W-1:0] a,
                                                   input logic [2:0]        sz);
    logic [ADDR_W-1:0] nbytes;
    logic [ADDR_W-1:0] lane_mask;
    logic [ADDR_W-1:0] lo;
    logic [ADDR_W-1:0] hi;
    nbytes    = ADDR_W'(1) << sz;
    lane_mask = ADDR_W'(DATA_BYTES - 1);
    lo        = a & lane_mask;
    hi        = ((a & ~(nbytes - ADDR_W'(1))) & lane_mask) + nbytes - ADDR_W'(1);
    strb_f    = '0;
    for (int i = 0; i < int'(DATA_BYTES); i++) begin
      strb_f[i] = (ADDR_W'(i) >= lo) && (ADDR_W'(i) <= hi);
    end
  endfunction

  logic [ADDR_W-1:0] req_b;
  logic [ADDR_W-1:0] req_aligned;
  logic [ADDR_W-1:0] req_span;
  logic [ADDR_W-1:0] wrap_lo_d;
  logic [ADDR_W-1:0] wrap_hi_d;
  logic [AW1-1:0]    incr_end;
  logic              crosses_4k;
  logic              wrap_len_ok;
  logic              req_err;

  // Request legality and wrap window, evaluated on the live request inputs.
  always_comb begin
    req_b       = ADDR_W'(1) << bus.req_size;
    req_aligned = bus.req_addr & ~(req_b - ADDR_W'(1));
    req_span    = (ADDR_W'(bus.req_len) + ADDR_W'(1)) << bus.req_size;
    wrap_lo_d   = bus.req_addr & ~(req_span - ADDR_W'(1));
    wrap_hi_d   = wrap_lo_d + req_span;
    incr_end    = AW1'(req_aligned) + AW1'(req_span) - AW1'(1);
    crosses_4k  = (incr_end >> 12) != (AW1'(req_aligned) >> 12);
    wrap_len_ok = (bus.req_len == 8'd1) || (bus.req_len == 8'd3) ||
                  (bus.req_len == 8'd7) || (bus.req_len == 8'd15);
    req_err     = (bus.req_burst == BURST_RESV) ||
                  (bus.req_size > 3'(LOG2_DB)) ||
                  ((bus.req_burst == BURST_WRAP) && !wrap_len_ok) ||
                  ((bus.req_burst == BURST_WRAP) && ((bus.req_addr & (req_b - ADDR_W'(1))) != '0)) ||
                  ((bus.req_burst == BURST_INCR) && crosses_4k);
  end

  logic [ADDR_W-1:0]     cur_b;
  logic [ADDR_W-1:0]     next_lin;
  logic [ADDR_W-1:0]     next_addr_d;
  logic [DATA_BYTES-1:0] next_strb_d;
  logic [7:0]            next_idx_d;

  // Address of the following beat; after beat 0 every beat is size-aligned.
  always_comb begin
    cur_b       = ADDR_W'(1) << size_q;
    next_lin    = (beat_addr_q & ~(cur_b - ADDR_W'(1))) + cur_b;
    next_addr_d = next_lin;
    if (burst_q == BURST_FIXED) begin
      next_addr_d = beat_addr_q;
    end else if ((burst_q == BURST_WRAP) && (next_lin == wrap_hi_q)) begin
      next_addr_d = wrap_lo_q;
    end
    next_strb_d = strb_f(next_addr_d, size_q);
    next_idx_d  = beat_idx_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      beat_valid_q <= 1'b0;
      beat_id_q    <= '0;
      beat_addr_q  <= '0;
      beat_strb_q  <= '0;
      beat_idx_q   <= '0;
      beat_last_q  <= 1'b0;
      err_valid_q  <= 1'b0;
      err_id_q     <= '0;
      err_resp_q   <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      wrap_lo_q    <= '0;
      wrap_hi_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            len_q       <= bus.req_len;
            size_q      <= bus.req_size;
            burst_q     <= bus.req_burst;
            wrap_lo_q   <= wrap_lo_d;
            wrap_hi_q   <= wrap_hi_d;
            if (req_err) begin
              state_q     <= S_ERR;
              err_valid_q <= 1'b1;
              err_id_q    <= bus.req_id;
              err_resp_q  <= RESP_SLVERR;
            end else begin
              state_q      <= S_BURST;
              beat_valid_q <= 1'b1;
              beat_id_q    <= bus.req_id;
              beat_addr_q  <= bus.req_addr;
              beat_strb_q  <= strb_f(bus.req_addr, bus.req_size);
              beat_idx_q   <= '0;
              beat_last_q  <= (bus.req_len == 8'd0);
            end
          end
        end
        S_BURST: begin
          if (bus.beat_ready) begin
            if (beat_last_q) begin
              state_q      <= S_IDLE;
              beat_valid_q <= 1'b0;
              req_ready_q  <= 1'b1;
            end else begin
              beat_addr_q <= next_addr_d;
              beat_strb_q <= next_strb_d;
              beat_idx_q  <= next_idx_d;
              beat_last_q <= (next_idx_d == len_q);
            end
          end
        end
        S_ERR: begin
          state_q     <= S_IDLE;
          err_valid_q <= 1'b0;
          err_resp_q  <= '0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.beat_valid = beat_valid_q;
  assign bus.beat_id    = beat_id_q;
  assign bus.beat_addr  = beat_addr_q;
  assign bus.beat_strb  = beat_strb_q;
  assign bus.beat_idx   = beat_idx_q;
  assign bus.beat_last  = beat_last_q;
  assign bus.err_valid  = err_valid_q;
  assign bus.err_id     = err_id_q;
  assign bus.err_resp   = err_resp_q;

endmodule
